ps_packet_arbiter: RTL

PS_PACKET_ARBITER -- requirements
Module: ps_packet_arbiter

---
 rtl/ps_packet_arbiter_pkg.sv | 10 +
 rtl/ps_rr_selector.sv | 31 +++
 rtl/ps_packet_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ps_packet_arbiter_pkg.sv
// Shared types for the packet-granular round-robin arbiter.
// The arbiter FSM is two-state: waiting for a grant decision, or forwarding one packet.
package ps_packet_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/ps_rr_selector.sv
// Combinational round-robin search: the first requesting channel above 'last', wrapping around.
// 'any' is the OR of all requests, and 'index' is valid only while 'any' is high.
module ps_rr_selector #(
  parameter int CHANNELS = 4,
  parameter int CWIDTH   = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CWIDTH-1:0]   last,
  output logic [CWIDTH-1:0]   index,
  output logic                any
);

  // NOTE: every output and temporary gets a default before the loop, so no latch is inferred.
  always_comb begin
    int   cand;
    logic found;
    index = '0;
    found = 1'b0;
    cand  = 0;
    any   = |req;
    // Offsets 1..CHANNELS put 'last' itself at lowest priority.
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = (int'(last) + k) % CHANNELS;
      if (!found && req[cand]) begin
        index = CWIDTH'(cand);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps_packet_arbiter.sv
// Packet-granular round-robin arbiter: it merges CHANNELS valid/ready streams into one.
// Define PS_PACKET_ARBITER_OREG_EN to add a full-throughput output register stage.
module ps_packet_arbiter
  import ps_packet_arbiter_pkg::*;
#(
  parameter  int DWIDTH   = 8,
  parameter  int CHANNELS = 4,
  localparam int CWIDTH   = $clog2(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHANNELS*DWIDTH-1:0] i_dat,
  input  logic [CHANNELS-1:0]        i_val,
  input  logic [CHANNELS-1:0]        i_eop,
  output logic [CHANNELS-1:0]        i_rdy,
  output logic [DWIDTH-1:0]          o_dat,
  output logic                       o_val,
  output logic                       o_eop,
  output logic [CWIDTH-1:0]          o_chan,
  input  logic                       o_rdy
);

  state_t              state;
  logic [CWIDTH-1:0]   sel;
  logic [CWIDTH-1:0]   last;
  logic [CWIDTH-1:0]   rr_index;
  logic                rr_any;

  logic                busy;
  logic [DWIDTH-1:0]   cur_dat;
  logic                cur_eop;
  logic                up_val;
  logic                up_rdy;
  logic                up_xfer;

  ps_rr_selector #(
    .CHANNELS (CHANNELS),
    .CWIDTH   (CWIDTH)
  ) u_rr_selector (
    .req   (i_val),
    .last  (last),
    .index (rr_index),
    .any   (rr_any)
  );

  assign busy    = (state == BUSY);
  assign cur_dat = i_dat[sel*DWIDTH +: DWIDTH];
  assign cur_eop = i_eop[sel];
  assign up_val  = busy & i_val[sel];
  assign up_xfer = up_val & up_rdy;

  // Only the granted channel can see ready; a stalled channel keeps its grant.
  always_comb begin
    i_rdy      = '0;
    if (busy) begin
      i_rdy[sel] = up_rdy;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every reader sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      last  <= CWIDTH'(CHANNELS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (rr_any) begin
            sel   <= rr_index;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (up_xfer && cur_eop) begin
            last  <= sel;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PS_PACKET_ARBITER_OREG_EN
  logic              reg_val;
  logic [DWIDTH-1:0] reg_dat;
  logic              reg_eop;
  logic [CWIDTH-1:0] reg_chan;

  // The skid-free stage refills in the same cycle it drains, which keeps throughput at one word per cycle.
  assign up_rdy = ~reg_val | o_rdy;

  // NOTE: the data fields are also reset, so the stage never shows stale values after an abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_val  <= 1'b0;
      reg_dat  <= '0;
      reg_eop  <= 1'b0;
      reg_chan <= '0;
    end else if (up_rdy) begin
      reg_val <= up_val;
      if (up_val) begin
        reg_dat  <= cur_dat;
        reg_eop  <= cur_eop;
        reg_chan <= sel;
      end
    end
  end

  assign o_dat  = reg_dat;
  assign o_val  = reg_val;
  assign o_eop  = reg_eop;
  assign o_chan = reg_chan;
`else
  assign up_rdy = o_rdy;
  assign o_dat  = cur_dat;
  assign o_val  = up_val;
  assign o_eop  = busy & cur_eop;
  assign o_chan = sel;
`endif

endmodule
